// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master: FSM state encoding and mode constants.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_DONE,
    ST_GAP
  } spi_state_e;

  localparam int unsigned DATA_BITS_DEF = 8;
  localparam int unsigned CPOL_DEF      = 0;
  localparam int unsigned CPHA_DEF      = 1;
  localparam int unsigned BRDV_DEF      = 2;
  localparam int unsigned LSBF_DEF      = 0;
  localparam int unsigned WCNT_W        = 6;

endpackage

// File: rtl/spi_clk_div.sv
// BRDV tick generator: one-clk tick every BRDV cycles while enabled, held at zero otherwise.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned BRDV = BRDV_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_en,
  output logic o_tick_c
);

  localparam int unsigned CW = (BRDV > 1) ? $clog2(BRDV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap   = (r_cnt == CW'(BRDV - 1));
  assign o_tick_c = i_en && w_wrap;

  // State changes only happen on a tick, so the wrap doubles as the clear on state entry.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (!i_en || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-lane SPI master: elaboration-time mode, bit order and divider; burst or per-word SS framing.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned CPOL      = CPOL_DEF,
  parameter int unsigned CPHA      = CPHA_DEF,
  parameter int unsigned BRDV      = BRDV_DEF,
  parameter int unsigned LSBF      = LSBF_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 spi_en,
  input  logic                 tied_SS,
  input  logic                 MISO,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [WCNT_W-1:0]    data_words,
  output logic                 SCK,
  output logic                 SS,
  output logic                 MOSI,
  output logic                 ready_out,
  output logic                 valid_out,
  output logic [DATA_BITS-1:0] data_out
);

  localparam int unsigned EW       = $clog2(2 * DATA_BITS + 1);
  localparam logic        SCK_IDLE = 1'(CPOL);
  localparam logic        PHA1     = (CPHA != 0);
  localparam logic        LSB1     = (LSBF != 0);

  spi_state_e           r_state;
  logic [EW-1:0]        r_edge;
  logic [DATA_BITS-1:0] r_tx;
  logic [DATA_BITS-1:0] r_rx;
  logic [WCNT_W-1:0]    r_words;

  logic                 w_tick;
  logic                 w_div_en;
  logic                 w_leading;
  logic                 w_last;
  logic                 w_drive;
  logic                 w_sample;
  logic                 w_tx_bit;
  logic [DATA_BITS-1:0] w_tx_shift;
  logic [DATA_BITS-1:0] w_rx_shift;
  logic                 w_din_bit;
  logic [DATA_BITS-1:0] w_din_shift;
  logic [DATA_BITS-1:0] w_tx_load;
  logic                 w_mosi_load;
  logic                 w_more_words;

  assign w_div_en = (r_state == ST_SETUP) || (r_state == ST_XFER) || (r_state == ST_HOLD);

  spi_clk_div #(.BRDV(BRDV)) u_clk_div (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_en     (w_div_en),
    .o_tick_c (w_tick)
  );

  // Edges are numbered from 1; odd-numbered edges are leading edges.
  assign w_leading = ~r_edge[0];
  assign w_last    = (r_edge == EW'(2 * DATA_BITS - 1));
  assign w_drive   = PHA1 ? w_leading : (!w_leading && !w_last);
  assign w_sample  = PHA1 ? !w_leading : w_leading;

  assign w_tx_bit    = LSB1 ? r_tx[0] : r_tx[DATA_BITS-1];
  assign w_tx_shift  = LSB1 ? {1'b0, r_tx[DATA_BITS-1:1]} : {r_tx[DATA_BITS-2:0], 1'b0};
  assign w_rx_shift  = LSB1 ? {MISO, r_rx[DATA_BITS-1:1]} : {r_rx[DATA_BITS-2:0], MISO};
  assign w_din_bit   = LSB1 ? data_in[0] : data_in[DATA_BITS-1];
  assign w_din_shift = LSB1 ? {1'b0, data_in[DATA_BITS-1:1]} : {data_in[DATA_BITS-2:0], 1'b0};

  // With CPHA=0 the first bit must already be on MOSI when SETUP begins.
  assign w_tx_load   = PHA1 ? data_in : w_din_shift;
  assign w_mosi_load = PHA1 ? MOSI : w_din_bit;

  assign w_more_words = (r_words != WCNT_W'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_IDLE;
      r_edge    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_words   <= '0;
      SCK       <= SCK_IDLE;
      SS        <= 1'b1;
      MOSI      <= 1'b0;
      ready_out <= 1'b1;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (spi_en) begin
            r_words   <= (data_words == '0) ? WCNT_W'(1) : data_words;
            r_tx      <= w_tx_load;
            MOSI      <= w_mosi_load;
            r_edge    <= '0;
            SS        <= 1'b0;
            ready_out <= 1'b0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tick) r_state <= ST_XFER;
        end
        ST_XFER: begin
          if (w_tick) begin
            SCK    <= ~SCK;
            r_edge <= r_edge + EW'(1);
            if (w_drive) begin
              MOSI <= w_tx_bit;
              r_tx <= w_tx_shift;
            end
            if (w_sample) r_rx <= w_rx_shift;
            if (w_last) r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            data_out  <= r_rx;
            valid_out <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_words   <= r_words - WCNT_W'(1);
          ready_out <= 1'b1;
          if (!tied_SS && w_more_words) begin
            r_state <= ST_GAP;
          end else begin
            SS      <= 1'b1;
            MOSI    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (spi_en) begin
            r_tx      <= w_tx_load;
            MOSI      <= w_mosi_load;
            r_edge    <= '0;
            ready_out <= 1'b0;
            r_state   <= ST_SETUP;
          end else if (tied_SS) begin
            SS      <= 1'b1;
            MOSI    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: mode-1 MSB-first instance against a slave model, and a
// CPOL=1/CPHA=0/LSB-first BRDV=1 instance in MOSI->MISO loopback.
module tb_spi_master;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         acc;
  } exp_t;

  localparam int LAT_A = (2 * 8 + 2) * 2 + 1;
  localparam int LAT_B = (2 * 8 + 2) * 1 + 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: mode 1, MSB first, BRDV=2
  logic       a_en = 1'b0, a_tied = 1'b0, a_miso = 1'b0;
  logic [7:0] a_din = '0;
  logic [5:0] a_words = '0;
  logic       a_sck, a_ss, a_mosi, a_rdy, a_vld;
  logic [7:0] a_dout;

  spi_master #(.DATA_BITS(8), .CPOL(0), .CPHA(1), .BRDV(2), .LSBF(0)) dut_a (
    .clk(clk), .n_rst(n_rst), .spi_en(a_en), .tied_SS(a_tied), .MISO(a_miso),
    .data_in(a_din), .data_words(a_words), .SCK(a_sck), .SS(a_ss), .MOSI(a_mosi),
    .ready_out(a_rdy), .valid_out(a_vld), .data_out(a_dout));

  // Instance B: CPOL=1, CPHA=0, LSB first, BRDV=1, loopback
  logic       b_en = 1'b0;
  logic [7:0] b_din = '0;
  logic       b_tied, b_miso;
  logic [5:0] b_words;
  logic       b_sck, b_ss, b_mosi, b_rdy, b_vld;
  logic [7:0] b_dout;
  assign b_tied  = 1'b1;
  assign b_words = 6'd1;
  assign b_miso  = b_mosi;

  spi_master #(.DATA_BITS(8), .CPOL(1), .CPHA(0), .BRDV(1), .LSBF(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .spi_en(b_en), .tied_SS(b_tied), .MISO(b_miso),
    .data_in(b_din), .data_words(b_words), .SCK(b_sck), .SS(b_ss), .MOSI(b_mosi),
    .ready_out(b_rdy), .valid_out(b_vld), .data_out(b_dout));

  exp_t       qa[$];
  exp_t       qb[$];
  logic [7:0] slave_q[$];
  logic [7:0] cap_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Mode-1 slave: shift reply out on SCK rise, capture MOSI on SCK fall, MSB first.
  int         tot_rise = 0;
  int         s_rise = 0;
  int         s_fall = 0;
  logic [7:0] s_sh = '0;
  logic [7:0] s_cap = '0;
  always @(posedge a_sck or negedge a_sck or posedge a_ss) begin
    if (a_ss) begin
      s_rise = 0;
      s_fall = 0;
    end else if (a_sck) begin
      if (s_rise % 8 == 0) s_sh = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
      a_miso = s_sh[7];
      s_sh   = {s_sh[6:0], 1'b0};
      s_rise++;
      tot_rise++;
    end else begin
      s_cap = {s_cap[6:0], a_mosi};
      s_fall++;
      if (s_fall % 8 == 0) cap_q.push_back(s_cap);
    end
  end

  // Monitor A
  int   snap_rise = 0;
  logic a_chk_next = 1'b0;
  exp_t ea;
  always @(negedge clk) begin
    if (n_rst) begin
      if (a_chk_next) begin
        check("a_valid_width", 32'(a_vld), 32'd0);
        a_chk_next = 1'b0;
      end
      if (a_vld) begin
        if (qa.size() == 0) begin
          fail("a_unexpected_valid");
        end else begin
          ea = qa.pop_front();
          check("a_data_out", 32'(a_dout), 32'(ea.rx));
          check("a_latency", 32'(cyc - ea.acc), 32'(LAT_A));
          check("a_ready_with_valid", 32'(a_rdy), 32'd0);
          check("a_ss_at_valid", 32'(a_ss), 32'd0);
          check("a_sck_rises", 32'(tot_rise - snap_rise), 32'd8);
          if (cap_q.size() == 0) fail("a_mosi_word_missing");
          else check("a_mosi_word", 32'(cap_q.pop_front()), 32'(ea.tx));
        end
        a_chk_next = 1'b1;
      end
      if (a_rdy) snap_rise = tot_rise;
    end
  end

  // Monitor B
  exp_t eb;
  always @(negedge clk) begin
    if (n_rst && b_vld) begin
      if (qb.size() == 0) begin
        fail("b_unexpected_valid");
      end else begin
        eb = qb.pop_front();
        check("b_loopback_data", 32'(b_dout), 32'(eb.tx));
        check("b_latency", 32'(cyc - eb.acc), 32'(LAT_B));
        check("b_ready_with_valid", 32'(b_rdy), 32'd0);
      end
    end
  end

  task automatic wait_rdy_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (a_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail("a_ready_timeout");
  endtask

  task automatic send_a(input logic [7:0] tx, input logic [7:0] rx, input logic exp_ss);
    bit ok;
    wait_rdy_a(ok);
    if (ok) begin
      check("a_ss_before_accept", 32'(a_ss), 32'(exp_ss));
      check("a_sck_idle", 32'(a_sck), 32'd0);
      slave_q.push_back(rx);
      qa.push_back('{tx, rx, cyc});
      a_din = tx;
      a_en  = 1'b1;
      @(negedge clk);
      a_en  = 1'b0;
      a_din = 8'($urandom);
    end
  endtask

  task automatic burst_end_a();
    bit ok;
    wait_rdy_a(ok);
    if (ok) check("a_ss_burst_end", 32'(a_ss), 32'd1);
  endtask

  task automatic seq_a();
    bit ok;
    logic [7:0] tx_list[4];
    logic [7:0] rx_list[4];
    bit   tied;
    int   w;
    int   n;
    tx_list = '{8'hFA, 8'hFB, 8'hFC, 8'hFE};
    rx_list = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    // Four-word burst under one SS
    a_tied = 1'b0; a_words = 6'd4;
    for (int k = 0; k < 4; k++) send_a(tx_list[k], rx_list[k], (k == 0));
    burst_end_a();
    // Single framed word
    a_tied = 1'b1; a_words = 6'd1;
    send_a(8'hA5, 8'h3C, 1'b1);
    burst_end_a();
    // data_words=0 behaves as one word
    a_tied = 1'b0; a_words = 6'd0;
    send_a(8'h5A, 8'hC3, 1'b1);
    burst_end_a();
    // spi_en while busy is ignored
    a_tied = 1'b1; a_words = 6'd1;
    send_a(8'h81, 8'h7E, 1'b1);
    repeat (12) @(negedge clk);
    check("a_busy_not_ready", 32'(a_rdy), 32'd0);
    a_din = 8'h99; a_en = 1'b1;
    @(negedge clk);
    a_en = 1'b0;
    burst_end_a();
    repeat (60) @(negedge clk);
    // tied_SS raised in GAP ends the burst
    a_tied = 1'b0; a_words = 6'd3;
    send_a(8'h12, 8'h34, 1'b1);
    wait_rdy_a(ok);
    check("a_gap_ss_low", 32'(a_ss), 32'd0);
    a_tied = 1'b1;
    repeat (2) @(negedge clk);
    check("a_gap_release_ss", 32'(a_ss), 32'd1);
    check("a_gap_release_rdy", 32'(a_rdy), 32'd1);
    // Randomised bursts
    for (int b = 0; b < 10; b++) begin
      tied = 1'($urandom_range(0, 1));
      w    = int'($urandom_range(0, 4));
      n    = tied ? int'($urandom_range(1, 2)) : ((w == 0) ? 1 : w);
      a_tied  = tied;
      a_words = 6'(w);
      for (int k = 0; k < n; k++) send_a(8'($urandom), 8'($urandom), (tied || k == 0));
      burst_end_a();
    end
  endtask

  task automatic seq_b();
    logic [7:0] tx;
    bit ok;
    for (int i = 0; i < 12; i++) begin
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        if (b_rdy) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) begin
        fail("b_ready_timeout");
        return;
      end
      check("b_sck_idle_high", 32'(b_sck), 32'd1);
      tx = (i == 0) ? 8'h01 : 8'($urandom);
      qb.push_back('{tx, tx, cyc});
      b_din = tx; b_en = 1'b1;
      @(negedge clk);
      b_en = 1'b0; b_din = 8'($urandom);
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (!b_sck) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) fail("b_first_fall_timeout");
      else check("b_first_bit", 32'(b_mosi), 32'(tx[0]));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_a_ss", 32'(a_ss), 32'd1);
    check("rst_a_sck", 32'(a_sck), 32'd0);
    check("rst_a_mosi", 32'(a_mosi), 32'd0);
    check("rst_a_rdy", 32'(a_rdy), 32'd1);
    check("rst_a_vld", 32'(a_vld), 32'd0);
    check("rst_a_dout", 32'(a_dout), 32'd0);
    check("rst_b_sck", 32'(b_sck), 32'd1);
    n_rst = 1'b1;
    @(negedge clk);
    fork
      seq_a();
      seq_b();
    join
    repeat (60) @(negedge clk);
    // Reset in the middle of a word
    a_tied = 1'b1; a_words = 6'd1;
    send_a(8'hC7, 8'h6B, 1'b1);
    repeat (15) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("midrst_ss", 32'(a_ss), 32'd1);
    check("midrst_sck", 32'(a_sck), 32'd0);
    check("midrst_vld", 32'(a_vld), 32'd0);
    check("midrst_dout", 32'(a_dout), 32'd0);
    check("midrst_rdy", 32'(a_rdy), 32'd1);
    repeat (3) @(negedge clk);
    qa.delete();
    slave_q.delete();
    cap_q.delete();
    n_rst = 1'b1;
    @(negedge clk);
    send_a(8'h3E, 8'hE3, 1'b1);
    burst_end_a();
    repeat (20) @(negedge clk);
    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
